// File: rtl/dtack_generator_if.sv
// dtack_generator_if: 68000-side bus bundle for the DTACK generator.
// master = CPU/decoder side, slave = dtack_generator.
interface dtack_generator_if;
    logic       AS_IN;
    logic       RW_IN;
    logic       SEL_IN;
    logic [3:0] WAIT_IN;
    logic       EXECUTE_IN;
    logic       DTACK_OUT;
    logic       BERR_OUT;
    logic       RD_OUT;
    logic       WR_OUT;
    logic       BUSY_OUT;

    modport master (
        output AS_IN, RW_IN, SEL_IN, WAIT_IN, EXECUTE_IN,
        input  DTACK_OUT, BERR_OUT, RD_OUT, WR_OUT, BUSY_OUT
    );

    modport slave (
        input  AS_IN, RW_IN, SEL_IN, WAIT_IN, EXECUTE_IN,
        output DTACK_OUT, BERR_OUT, RD_OUT, WR_OUT, BUSY_OUT
    );
endinterface

// File: rtl/dtack_generator.sv
// dtack_generator: 68000 DTACK/BERR generator with wait states and step gate.
// Ports: MCLK_IN clock, RESET_IN async active-high reset, bus (slave):
//   AS_IN, RW_IN, SEL_IN, WAIT_IN[3:0], EXECUTE_IN in;
//   DTACK_OUT, BERR_OUT (active-low), RD_OUT, WR_OUT, BUSY_OUT out.
// Option: define DTACK_BERR_TIMEOUT_EN for the bus-error timeout path.
module dtack_generator #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic         MCLK_IN,
    input  logic         RESET_IN,
    dtack_generator_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BERR,
        S_RELEASE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ass;
    logic                   exec_q;
    logic [3:0]             cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    logic                   unmap_q, unmap_d;
    logic                   dtack_q, dtack_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic                   busy_q, busy_d;
    logic                   strb;

`ifdef DTACK_BERR_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
    logic [9:0] tmo_q, tmo_d;
    logic       berr_q, berr_d;
`endif

    assign ass = sync_q[SYNC_STAGES-1];

    always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            sync_q  <= '1;
            exec_q  <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            unmap_q <= 1'b0;
            dtack_q <= 1'b1;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DTACK_BERR_TIMEOUT_EN
            tmo_q   <= '0;
            berr_q  <= 1'b1;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.AS_IN};
            exec_q  <= bus.EXECUTE_IN;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            unmap_q <= unmap_d;
            dtack_q <= dtack_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
`ifdef DTACK_BERR_TIMEOUT_EN
            tmo_q   <= tmo_d;
            berr_q  <= berr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        unmap_d = unmap_q;
`ifdef DTACK_BERR_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!ass) begin
                    state_d = S_WAIT;
                    rw_d    = bus.RW_IN;
                    unmap_d = !bus.SEL_IN;
                    cnt_d   = bus.SEL_IN ? bus.WAIT_IN : 4'd15;
`ifdef DTACK_BERR_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                // An AS negation aborts the cycle before any gating.
                if (ass) begin
                    state_d = S_IDLE;
                end else if (exec_q) begin
                    if (cnt_q == 4'd0) begin
`ifdef DTACK_BERR_TIMEOUT_EN
                        state_d = unmap_q ? S_BERR : S_ACK;
`else
                        state_d = S_ACK;
`endif
                    end else begin
                        cnt_d = cnt_q - 4'd1;
`ifdef DTACK_BERR_TIMEOUT_EN
                        if (tmo_q == TMO_LAST) begin
                            state_d = S_BERR;
                        end else begin
                            tmo_d = tmo_q + 10'd1;
                        end
`endif
                    end
                end
            end
            S_ACK: begin
                if (ass) begin
                    state_d = S_IDLE;
                end
            end
            S_BERR: begin
                if (ass) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change on
        // the same edge as the state and never glitch.
        strb    = (state_d == S_WAIT || state_d == S_ACK) && !unmap_d;
        busy_d  = (state_d != S_IDLE);
        dtack_d = (state_d != S_ACK);
        rd_d    = strb && rw_d;
        wr_d    = strb && !rw_d;
`ifdef DTACK_BERR_TIMEOUT_EN
        berr_d  = (state_d != S_BERR);
`endif
    end

    assign bus.DTACK_OUT = dtack_q;
    assign bus.RD_OUT    = rd_q;
    assign bus.WR_OUT    = wr_q;
    assign bus.BUSY_OUT  = busy_q;
`ifdef DTACK_BERR_TIMEOUT_EN
    assign bus.BERR_OUT  = berr_q;
`else
    assign bus.BERR_OUT  = 1'b1;
`endif
endmodule

// File: tb/tb_dtack_generator.sv
// tb_dtack_generator: randomized bench for dtack_generator, two instances
// (default timeout and TIMEOUT=8) against an edge-count reference model.
module tb_dtack_generator;
    localparam int SS = 2;
    localparam int E1 = SS + 1;
`ifdef DTACK_BERR_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic [4:0] IDLE_V = 5'b00011;

    logic       clk = 1'b0;
    logic       rst;
    logic       as_s, rw_s, sel_s, exe_s;
    logic [3:0] wt_s;
    int         n_chk = 0;
    int         n_err = 0;
    int         tmo[2] = '{1023, 8};

    always #5 clk = ~clk;

    dtack_generator_if ifa();
    dtack_generator_if ifb();

    assign ifa.AS_IN      = as_s;
    assign ifa.RW_IN      = rw_s;
    assign ifa.SEL_IN     = sel_s;
    assign ifa.WAIT_IN    = wt_s;
    assign ifa.EXECUTE_IN = exe_s;
    assign ifb.AS_IN      = as_s;
    assign ifb.RW_IN      = rw_s;
    assign ifb.SEL_IN     = sel_s;
    assign ifb.WAIT_IN    = wt_s;
    assign ifb.EXECUTE_IN = exe_s;

    dtack_generator #(.SYNC_STAGES(SS), .TIMEOUT(1023)) dut_a (
        .MCLK_IN  (clk),
        .RESET_IN (rst),
        .bus      (ifa)
    );

    dtack_generator #(.SYNC_STAGES(SS), .TIMEOUT(8)) dut_b (
        .MCLK_IN  (clk),
        .RESET_IN (rst),
        .bus      (ifb)
    );

    // {busy, rd, wr, dtack_n, berr_n}
    logic [4:0] va, vb;
    assign va = {ifa.BUSY_OUT, ifa.RD_OUT, ifa.WR_OUT,
                 ifa.DTACK_OUT, ifa.BERR_OUT};
    assign vb = {ifb.BUSY_OUT, ifb.RD_OUT, ifb.WR_OUT,
                 ifb.DTACK_OUT, ifb.BERR_OUT};

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs at edge k. Cycle enters WAIT at E1, terminates at
    // edge t (0 = never), FSM first sees AS high at edge h.
    function automatic logic [4:0] expv(int k, int h, int t, bit b,
                                        bit sel, bit rw);
        logic [4:0] wv, av;
        wv = {1'b1, sel & rw, sel & ~rw, 2'b11};
        av = {1'b1, sel & rw, sel & ~rw, 2'b01};
        if (k < E1) return IDLE_V;
        if (t == 0 || k < t) return (k < h) ? wv : IDLE_V;
        if (k < h) return b ? 5'b10010 : av;
        if (k == h && b) return 5'b10011;
        return IDLE_V;
    endfunction

    // One bus cycle. Called just after an edge (edge 0). emode:
    // 0 = execute always, 1 = random, 2 = held low 50 clocks in WAIT.
    task automatic xact(input bit via_rst, input bit rw, input bit sel,
                        input int w, input int emode, input int hold);
        bit exh[0:127];
        int t[2];
        int n[2];
        bit b[2];
        int h;
        int wl;
        h  = E1 + hold + SS + 1;
        wl = sel ? w + 1 : 16;
        for (int d = 0; d < 2; d++) begin
            t[d] = 0;
            n[d] = 0;
            b[d] = 1'b0;
        end
        if (via_rst) rst = 1'b0;
        as_s  = 1'b0;
        rw_s  = rw;
        sel_s = sel;
        wt_s  = 4'(w);
        exe_s = (emode == 2) ? 1'b0 : 1'b1;
        exh[1] = exe_s;
        for (int k = 1; k <= h + 2; k++) begin
            @(posedge clk);
            #1;
            // Execute driven before edge k-1 gates the step at edge k.
            for (int d = 0; d < 2; d++) begin
                if (t[d] == 0 && k >= E1 + 1 && k < h && exh[k-1]) begin
                    n[d]++;
                    if (n[d] == wl) begin
                        t[d] = k;
                        b[d] = !sel && TMO_EN;
                    end else if (TMO_EN && n[d] == tmo[d]) begin
                        t[d] = k;
                        b[d] = 1'b1;
                    end
                end
            end
            check("out_a", va, expv(k, h, t[0], b[0], sel, rw));
            check("out_b", vb, expv(k, h, t[1], b[1], sel, rw));
            check("excl_a", ifa.DTACK_OUT | ifa.BERR_OUT, 1);
            check("excl_b", ifb.DTACK_OUT | ifb.BERR_OUT, 1);
            if (k == E1 + hold) as_s = 1'b1;
            if (k >= E1) begin
                rw_s  = 1'($urandom);
                sel_s = 1'($urandom);
                wt_s  = 4'($urandom);
            end
            case (emode)
                0: exe_s = 1'b1;
                1: exe_s = ($urandom_range(0, 3) != 0);
                default: exe_s = (k >= E1 + 50);
            endcase
            exh[k+1] = exe_s;
        end
    endtask

    task automatic rst_mid_ack();
        as_s  = 1'b0;
        rw_s  = 1'b1;
        sel_s = 1'b1;
        wt_s  = 4'd0;
        exe_s = 1'b1;
        repeat (E1 + 2) @(posedge clk);
        #1;
        check("pre_rst_ack", ifa.DTACK_OUT, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async_a", va, IDLE_V);
        check("rst_async_b", vb, IDLE_V);
        @(posedge clk);
        #1;
        xact(1'b1, 1'b1, 1'b1, 2, 0, 8);
    endtask

    initial begin
        rst   = 1'b1;
        as_s  = 1'b1;
        rw_s  = 1'b0;
        sel_s = 1'b0;
        wt_s  = 4'd0;
        exe_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", va, IDLE_V);
        check("reset_b", vb, IDLE_V);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_a", va, IDLE_V);
        xact(1'b0, 1'b1, 1'b1, 3, 0, 10);
        xact(1'b0, 1'b0, 1'b1, 0, 2, 55);
        xact(1'b0, 1'b1, 1'b0, 5, 0, 20);
        xact(1'b0, 1'b1, 1'b1, 15, 0, 20);
        xact(1'b0, 1'b1, 1'b1, 15, 0, 4);
        rst_mid_ack();
        repeat (40) begin
            xact(1'b0, 1'($urandom), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 15)), 1,
                 int'($urandom_range(0, 40)));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
